inst_stage_sequencer: RTL
=========================

Name: inst_stage_sequencer

Overview:
Generalised multi-stage instruction sequencer sitting between the fetch/instruction register and the scheduler.
- Expands each instruction into 1..MAX_STAGES micro-stages, each with a stage kind the decoder uses to steer dest/src/addr selection.
- Replaces the single hard-wired pre-stage with a table-driven stage counter.
- Adds interrupt entry: an injected push-PC, push-flags, jump-to-vector sequence at instruction boundaries.
- Gates immediate consumption per stage.

Parameters:
MAX_STAGES, 4, maximum micro-stages per sequence (>=3)
NSHIFT, 2, serial data bits per cycle
STAGE_BITS, $clog2(MAX_STAGES), stage index width
PC_PUSH_OFFSET, 2, value (in NSHIFT-bit units) driven on imm_override during PUSH_PC stages of a call
IRQ_VECTOR_SEL, 0, index of the vector-register source used in the IRQ_VECTOR stage

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_valid  in  1  instruction register holds a valid instruction
inst  in  16  current instruction
inst_done  out  1  instruction fully retired; fetch may advance
irq  in  1  level interrupt request
irq_en  in  1  interrupts enabled (flag from core)
irq_ack  out  1  one-cycle pulse when interrupt entry completes
irq_active  out  1  an interrupt-entry sequence is in progress
sc_stage_done  in  1  scheduler finished current micro-stage
sc_next_imm_data  in  1  scheduler wants next immediate chunk
next_imm_data  out  1  gated immediate advance to fetch unit
stage_valid  out  1  stage_kind is valid this cycle
stage_kind  out  3  NORMAL/PUSH_PC/PUSH_FLAGS/IRQ_VECTOR
stage_idx  out  STAGE_BITS  current micro-stage index
last_stage  out  1  current stage is final of its sequence
imm_override_valid  out  1  scheduler must use imm_override instead of fetched immediate
imm_override  out  NSHIFT  substitute immediate chunk

Behaviour:
- Reset values: stage_idx=0, sequence=NONE, irq_ack=0, irq_active=0, inst_done=0. stage_valid follows inst_valid combinationally.
- Sequence selection happens only when stage_idx==0 and sequence==NONE (boundary). Priority:
  - IRQ if irq && irq_en && inst_valid: stages PUSH_PC, PUSH_FLAGS, IRQ_VECTOR. The instruction is not consumed.
  - Else CALL if inst[15:6]==10'b0010000001: stages PUSH_PC, NORMAL.
  - Else PLAIN: NORMAL.
- The selection is latched in a sequence register on the first sc_stage_done. Later changes of irq/irq_en do not affect a started sequence.
- Stage 0 kind is combinational from inst/irq in the same cycle inst_valid rises (zero added latency).
- On sc_stage_done with !last_stage: stage_idx <= stage_idx+1 next cycle.
- On sc_stage_done with last_stage: stage_idx <= 0 and sequence <= NONE.
  - PLAIN/CALL: inst_done=1 combinationally that cycle.
  - IRQ: irq_ack=1 that cycle, inst_done=0, so the same instruction re-enters as PLAIN/CALL afterwards (irq_en is expected to be cleared by the core on ack).
- A one-stage PLAIN instruction completes with inst_done in the same cycle as sc_stage_done. No idle cycle between back-to-back instructions.
- irq_active=1 from the IRQ selection cycle through the ack cycle inclusive.
- next_imm_data = sc_next_imm_data && stage_kind==NORMAL. Immediates are never consumed in PUSH_PC, PUSH_FLAGS or IRQ_VECTOR.
- imm_override_valid=1 in PUSH_PC, PUSH_FLAGS and IRQ_VECTOR stages.
  - imm_override is PC_PUSH_OFFSET in CALL PUSH_PC, 0 in IRQ PUSH_PC (interrupted PC not advanced), 2 in PUSH_FLAGS, IRQ_VECTOR_SEL in IRQ_VECTOR.
- sc_stage_done while !inst_valid is ignored.
- Reset mid-sequence abandons it: no inst_done, no irq_ack.
- stage_idx never exceeds sequence length-1. Reaching MAX_STAGES-1 without last_stage is impossible by construction; an assertion covers it.

Decomposition:
- Shared package header (common.vh): STAGE_KIND_* constants (NORMAL=0, PUSH_PC=1, PUSH_FLAGS=2, IRQ_VECTOR=3), SEQ_* constants (NONE/PLAIN/CALL/IRQ), STAGE_KIND_BITS=3.
- One natural sub-module: stage_table (combinational sequence+index -> kind/last/override).
- Counter and sequence register live in the top module.

Test Plan:
- PLAIN: inst=16'h8123, inst_valid=1, sc_stage_done pulse at cycle 3 -> stage_kind=NORMAL, last_stage=1, inst_done=1 at cycle 3 only, stage_idx=0.
- CALL: inst=16'h2045 -> stage0 PUSH_PC with imm_override=2, next_imm_data masked; after done, stage1 NORMAL; inst_done only after 2nd sc_stage_done.
- IRQ: irq=1, irq_en=1 at boundary with inst=16'h8123 -> stages PUSH_PC (override 0), PUSH_FLAGS (2), IRQ_VECTOR; irq_ack on 3rd done; inst_done=0; next instruction runs PLAIN with irq_en=0.
- irq rises mid-CALL (stage1) -> CALL finishes with inst_done; IRQ sequence starts at next boundary.
- Reset asserted during IRQ stage1 -> next cycle stage_idx=0, irq_active=0, no irq_ack ever.
- Back-to-back PLAIN with sc_stage_done every cycle -> inst_done every cycle, stage_idx stays 0.

Source files
------------

// File: rtl/inst_stage_sequencer_pkg.sv
// Shared types for the instruction stage sequencer: stage kinds, sequence
// kinds and the per-sequence stage count.
package inst_stage_sequencer_pkg;

   localparam int STAGE_KIND_BITS = 3;

   typedef enum logic [STAGE_KIND_BITS-1:0] {
      STAGE_KIND_NORMAL     = 3'd0,
      STAGE_KIND_PUSH_PC    = 3'd1,
      STAGE_KIND_PUSH_FLAGS = 3'd2,
      STAGE_KIND_IRQ_VECTOR = 3'd3
   } stage_kind_e;

   typedef enum logic [1:0] {
      SEQ_NONE  = 2'd0,
      SEQ_PLAIN = 2'd1,
      SEQ_CALL  = 2'd2,
      SEQ_IRQ   = 2'd3
   } seq_e;

   // Upper ten opcode bits that mark a call instruction.
   localparam logic [9:0] CALL_OPCODE = 10'b0010000001;

   // Number of micro-stages in each sequence kind.
   function automatic int seq_len(input seq_e seq);
      case (seq)
         SEQ_PLAIN: return 1;
         SEQ_CALL:  return 2;
         SEQ_IRQ:   return 3;
         default:   return 0;
      endcase
   endfunction

endpackage

// File: rtl/inst_stage_sequencer_stage_table.sv
// Combinational stage table: (sequence, stage index) -> stage kind, final-stage
// flag and the substitute immediate used by the non-NORMAL stages.
module inst_stage_sequencer_stage_table
   import inst_stage_sequencer_pkg::*;
#(
   parameter int NSHIFT         = 2,
   parameter int STAGE_BITS     = 2,
   parameter int PC_PUSH_OFFSET = 2,
   parameter int IRQ_VECTOR_SEL = 0
) (
   input  seq_e                  seq,
   input  logic [STAGE_BITS-1:0] idx,
   output stage_kind_e           kind,
   output logic                  last,
   output logic                  ovr_valid,
   output logic [NSHIFT-1:0]     ovr
);

   // Table lookup; anything outside a defined sequence reads as a one-stage NORMAL.
   always_comb begin
      kind      = STAGE_KIND_NORMAL;
      last      = 1'b1;
      ovr_valid = 1'b0;
      ovr       = '0;
      case (seq)
         SEQ_CALL: begin
            if (idx == STAGE_BITS'(0)) begin
               kind      = STAGE_KIND_PUSH_PC;
               last      = 1'b0;
               ovr_valid = 1'b1;
               ovr       = NSHIFT'(PC_PUSH_OFFSET);
            end
         end
         SEQ_IRQ: begin
            if (idx == STAGE_BITS'(0)) begin
               // interrupted PC is pushed as-is, not advanced past the instruction
               kind      = STAGE_KIND_PUSH_PC;
               last      = 1'b0;
               ovr_valid = 1'b1;
               ovr       = '0;
            end else if (idx == STAGE_BITS'(1)) begin
               kind      = STAGE_KIND_PUSH_FLAGS;
               last      = 1'b0;
               ovr_valid = 1'b1;
               ovr       = NSHIFT'(2);
            end else begin
               kind      = STAGE_KIND_IRQ_VECTOR;
               last      = 1'b1;
               ovr_valid = 1'b1;
               ovr       = NSHIFT'(IRQ_VECTOR_SEL);
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/inst_stage_sequencer.sv
// Instruction stage sequencer: expands each instruction into table-driven
// micro-stages, injects interrupt entry at instruction boundaries and gates
// immediate consumption per stage.
module inst_stage_sequencer
   import inst_stage_sequencer_pkg::*;
#(
   parameter int MAX_STAGES     = 4,
   parameter int NSHIFT         = 2,
   parameter int STAGE_BITS     = $clog2(MAX_STAGES),
   parameter int PC_PUSH_OFFSET = 2,
   parameter int IRQ_VECTOR_SEL = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inst_valid,
   input  logic [15:0]           inst,
   output logic                  inst_done,
   input  logic                  irq,
   input  logic                  irq_en,
   output logic                  irq_ack,
   output logic                  irq_active,
   input  logic                  sc_stage_done,
   input  logic                  sc_next_imm_data,
   output logic                  next_imm_data,
   output logic                  stage_valid,
   output logic [2:0]            stage_kind,
   output logic [STAGE_BITS-1:0] stage_idx,
   output logic                  last_stage,
   output logic                  imm_override_valid,
   output logic [NSHIFT-1:0]     imm_override
);

   seq_e                  seq_q;
   seq_e                  sel_seq;
   seq_e                  eff_seq;
   logic [STAGE_BITS-1:0] stage_idx_q;
   stage_kind_e           kind;
   logic                  last;
   logic                  boundary;
   logic                  advance;
   logic                  finish;
   logic                  unused_inst_low;

   assign unused_inst_low = ^inst[5:0];

   assign boundary = (stage_idx_q == '0) && (seq_q == SEQ_NONE);
   assign advance  = inst_valid && sc_stage_done;
   assign finish   = advance && last;

   // Candidate sequence at a boundary; interrupt entry wins over the instruction.
   always_comb begin
      sel_seq = SEQ_PLAIN;
      if (irq && irq_en && inst_valid) begin
         sel_seq = SEQ_IRQ;
      end else if (inst[15:6] == CALL_OPCODE) begin
         sel_seq = SEQ_CALL;
      end
   end

   // Stage 0 decodes live so a new instruction costs no extra cycle.
   assign eff_seq = boundary ? sel_seq : seq_q;

   inst_stage_sequencer_stage_table #(
      .NSHIFT         (NSHIFT),
      .STAGE_BITS     (STAGE_BITS),
      .PC_PUSH_OFFSET (PC_PUSH_OFFSET),
      .IRQ_VECTOR_SEL (IRQ_VECTOR_SEL)
   ) u_stage_table (
      .seq       (eff_seq),
      .idx       (stage_idx_q),
      .kind      (kind),
      .last      (last),
      .ovr_valid (imm_override_valid),
      .ovr       (imm_override)
   );

   // Stage counter and sequence register; the selection is frozen on the first done.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_idx_q <= '0;
         seq_q       <= SEQ_NONE;
      end else if (advance) begin
         if (last) begin
            stage_idx_q <= '0;
            seq_q       <= SEQ_NONE;
         end else begin
            stage_idx_q <= stage_idx_q + STAGE_BITS'(1);
            seq_q       <= eff_seq;
         end
      end
   end

   // Completion strobes are suppressed in a reset cycle so an abandoned sequence never retires.
   assign inst_done     = !reset && finish && (eff_seq != SEQ_IRQ);
   assign irq_ack       = !reset && finish && (eff_seq == SEQ_IRQ);
   assign irq_active    = !reset && (eff_seq == SEQ_IRQ);

   assign stage_valid   = inst_valid;
   assign stage_kind    = kind;
   assign stage_idx     = stage_idx_q;
   assign last_stage    = last;
   assign next_imm_data = sc_next_imm_data && (kind == STAGE_KIND_NORMAL);

   // The counter must stay inside its sequence and never run off the end of the table.
   a_idx_in_range: assert property (@(posedge clk) disable iff (reset)
      (seq_q == SEQ_NONE) || (int'(stage_idx_q) < seq_len(seq_q)));
   a_no_overrun: assert property (@(posedge clk) disable iff (reset)
      !((int'(stage_idx_q) == MAX_STAGES - 1) && !last));

endmodule
